if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage pipelined CPU, directly upstream of decode.
- Owns the PC register, drives the instruction-memory word address, and registers the fetched instruction into the IF/ID pipeline register.
- Honours stall and flush from the hazard unit and branch/jump redirects resolved in EX.

Parameters:
- RESET_PC, 32'h0000_0000, byte address of the first fetch after reset.
- IMEM_AW, 8, instruction-memory word-address width (256 words).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- stall_i  input  1  hazard unit: hold PC and IF/ID contents.
- flush_i  input  1  hazard unit: load a bubble into IF/ID.
- redirect_valid_i  input  1  EX resolved a taken branch or jump.
- redirect_pc_i  input  32  target byte address for the redirect.
- imem_addr_o  output  IMEM_AW  word address, equal to pc[IMEM_AW+1:2].
- imem_rdata_i  input  32  instruction word; combinational read, valid in the same cycle.
- ifid_valid_o  output  1  IF/ID holds a real instruction.
- ifid_pc_o  output  32  PC of the instruction in IF/ID.
- ifid_pc4_o  output  32  ifid_pc_o + 4, for link and branch-offset use.
- ifid_instr_o  output  32  instruction in IF/ID.
- misaligned_o  output  1  sticky flag: a redirect target had bits [1:0] != 0.
- perf_fetch_cnt_o  output  32  fetch counter (see Optional Feature).
- perf_stall_cnt_o  output  32  stall counter (see Optional Feature).
- perf_flush_cnt_o  output  32  flush counter (see Optional Feature).

Behaviour:
- Reset (async, while rst_n=0): pc=RESET_PC; ifid_valid_o=0; ifid_pc_o=0; ifid_pc4_o=0; ifid_instr_o=NOP_INSTR (32'h0); misaligned_o=0; all perf counters 0.
- Next-PC priority, highest first:
  - redirect_valid_i: pc <= {redirect_pc_i[31:2],2'b00}; misaligned_o <= misaligned_o | (redirect_pc_i[1:0]!=0).
  - stall_i: pc holds.
  - otherwise: pc <= pc + 4, modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- A redirect overrides a simultaneous stall (the PC still moves).
- IF/ID update, highest priority first:
  - flush_i or redirect_valid_i: bubble; valid=0, instr=NOP_INSTR, pc and pc4 = 0.
  - stall_i: hold all IF/ID fields.
  - otherwise: valid=1, pc=pc, pc4=pc+4, instr=imem_rdata_i.
- Latency: an instruction at address A appears on ifid_* one rising edge after pc==A, absent stall/flush.
  - After rst_n deasserts, the first rising edge loads IF/ID with the instruction at RESET_PC.
- A taken branch costs one bubble from this stage. EX-stage flushing of ID is done by the hazard unit, not here.
- Reset asserted mid-stall or mid-redirect: immediate return to reset values; no pending redirect survives.
- imem_addr_o is combinational from the pc register only, never from the next-PC mux, so it is glitch-free relative to redirect inputs.
- Only bits [IMEM_AW+1:2] of the PC address memory; higher bits are carried in ifid_pc_o but otherwise ignored.

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- Defined: three 32-bit saturating counters (stick at 32'hFFFF_FFFF):
  - fetch counter: increments each cycle IF/ID captures a valid instruction.
  - stall counter: increments each cycle stall_i=1 and no redirect.
  - flush counter: increments each cycle flush_i|redirect_valid_i.
  - All three clear on reset.
- Not defined: the perf_* ports remain present and are tied to 32'h0; no counter flops are synthesised.

Decomposition:
- Shared package cpu_pkg: XLEN=32, NOP_INSTR=32'h0000_0000, DEFAULT_RESET_PC, and a PC_INC=4 constant.
- One natural sub-module, if_id_reg: the IF/ID register, with bubble/hold/load controls and NOP_INSTR fill.
- if_stage keeps the PC, next-PC mux, misaligned flag and the optional counters.

Test Plan:
- Reset then free-run, IMEM[i]=32'h2000_0000+i: after 3 edges ifid_pc_o=8, ifid_instr_o=32'h2000_0002, ifid_valid_o=1; imem_addr_o=3.
- stall_i=1 for 2 cycles while ifid_pc_o=4: ifid_pc_o and ifid_instr_o hold; pc stays 8; fetch resumes with ifid_pc_o=8 on the edge after stall drops.
- redirect_valid_i=1 with redirect_pc_i=32'h40 and stall_i=1 together: next edge ifid_valid_o=0, ifid_instr_o=0, pc=32'h40; following edge ifid_pc_o=32'h40.
- redirect_pc_i=32'h42: pc becomes 32'h40 and misaligned_o=1. misaligned_o stays 1 through later valid redirects and clears only on rst_n=0.
- Force pc to 32'hFFFF_FFFC via redirect, then no stall: next pc=0, ifid_pc4_o=0 for the FFFC instruction. Assert rst_n=0 mid-cycle: all outputs reach reset values before the next edge.
- With IF_PERF_CNT_EN defined, run 10 fetches, 3 stalls, 2 flushes: counters read 10/3/2. Without the macro, all perf_* read 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
// Shared constants and types for the 5-stage pipelined CPU.
//   XLEN             : datapath width
//   NOP_INSTR        : bubble instruction loaded into pipeline registers
//   DEFAULT_RESET_PC : default byte address of the first fetch after reset
//   PC_INC           : sequential PC increment (one 32-bit word)
//   ifid_ctrl_e      : IF/ID register control (load / hold / bubble)
//   sat_inc          : saturating 32-bit increment for event counters
// ----------------------------------------------------------------------------
package cpu_pkg;

    localparam int unsigned XLEN             = 32;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_INC           = 32'd4;

    typedef enum logic [1:0] {
        IFID_LOAD   = 2'd0,
        IFID_HOLD   = 2'd1,
        IFID_BUBBLE = 2'd2
    } ifid_ctrl_e;

    // Sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/if_stage_if_id_reg.sv
// ----------------------------------------------------------------------------
// if_id_reg
// IF/ID pipeline register with bubble / hold / load controls.
// A bubble clears valid and both PC fields and fills the instruction with
// NOP_INSTR; hold keeps every field; load captures the fetched instruction.
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   i_ctrl      : IFID_LOAD / IFID_HOLD / IFID_BUBBLE
//   i_pc        : PC of the instruction being fetched
//   i_pc4       : i_pc + 4
//   i_instr     : fetched instruction word
//   o_valid     : register holds a real instruction
//   o_pc/o_pc4  : registered PC and PC+4
//   o_instr     : registered instruction
// ----------------------------------------------------------------------------
module if_id_reg
    import cpu_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  ifid_ctrl_e       i_ctrl,
    input  logic [XLEN-1:0]  i_pc,
    input  logic [XLEN-1:0]  i_pc4,
    input  logic [XLEN-1:0]  i_instr,
    output logic             o_valid,
    output logic [XLEN-1:0]  o_pc,
    output logic [XLEN-1:0]  o_pc4,
    output logic [XLEN-1:0]  o_instr
);

    logic            r_valid;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_pc4;
    logic [XLEN-1:0] r_instr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_pc4   <= '0;
            r_instr <= NOP_INSTR;
        end else begin
            case (i_ctrl)
                IFID_BUBBLE: begin
                    r_valid <= 1'b0;
                    r_pc    <= '0;
                    r_pc4   <= '0;
                    r_instr <= NOP_INSTR;
                end
                IFID_LOAD: begin
                    r_valid <= 1'b1;
                    r_pc    <= i_pc;
                    r_pc4   <= i_pc4;
                    r_instr <= i_instr;
                end
                default: ;
            endcase
        end
    end

    assign o_valid = r_valid;
    assign o_pc    = r_pc;
    assign o_pc4   = r_pc4;
    assign o_instr = r_instr;

endmodule

// File: rtl/if_stage.sv
// ----------------------------------------------------------------------------
// if_stage
// Instruction-fetch stage: owns the PC, drives the instruction-memory word
// address and feeds the IF/ID register (if_id_reg).
// Next-PC priority: redirect > stall > PC+4 (wraps modulo 2^32).
// IF/ID priority  : flush|redirect (bubble) > stall (hold) > load.
// Ports:
//   clk, rst_n         : clock, async active-low reset
//   stall_i, flush_i   : hazard-unit controls
//   redirect_valid_i   : taken branch/jump from EX
//   redirect_pc_i      : redirect byte target (bits [1:0] dropped)
//   imem_addr_o        : word address = pc[IMEM_AW+1:2], from the PC flop only
//   imem_rdata_i       : combinational instruction read data
//   ifid_*_o           : IF/ID register contents
//   misaligned_o       : sticky, set by any redirect target with [1:0] != 0
//   perf_*_cnt_o       : saturating fetch/stall/flush counters
// Configuration: macro IF_PERF_CNT_EN enables the counters; when undefined
// the perf_* ports are tied to zero and no counter flops exist.
// ----------------------------------------------------------------------------
module if_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned IMEM_AW  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall_i,
    input  logic               flush_i,
    input  logic               redirect_valid_i,
    input  logic [XLEN-1:0]    redirect_pc_i,
    output logic [IMEM_AW-1:0] imem_addr_o,
    input  logic [XLEN-1:0]    imem_rdata_i,
    output logic               ifid_valid_o,
    output logic [XLEN-1:0]    ifid_pc_o,
    output logic [XLEN-1:0]    ifid_pc4_o,
    output logic [XLEN-1:0]    ifid_instr_o,
    output logic               misaligned_o,
    output logic [XLEN-1:0]    perf_fetch_cnt_o,
    output logic [XLEN-1:0]    perf_stall_cnt_o,
    output logic [XLEN-1:0]    perf_flush_cnt_o
);

    logic [XLEN-1:0] r_pc;
    logic            r_misaligned;
    logic [XLEN-1:0] w_pc4;
    logic [XLEN-1:0] w_next_pc;
    logic            w_bubble;
    logic            w_load;
    ifid_ctrl_e      w_ifid_ctrl;

    assign w_pc4    = r_pc + PC_INC;
    assign w_bubble = flush_i | redirect_valid_i;
    assign w_load   = !w_bubble && !stall_i;

    always_comb begin
        w_next_pc = w_pc4;
        if (redirect_valid_i)
            w_next_pc = {redirect_pc_i[XLEN-1:2], 2'b00};
        else if (stall_i)
            w_next_pc = r_pc;
    end

    always_comb begin
        w_ifid_ctrl = IFID_LOAD;
        if (w_bubble)
            w_ifid_ctrl = IFID_BUBBLE;
        else if (stall_i)
            w_ifid_ctrl = IFID_HOLD;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc         <= RESET_PC;
            r_misaligned <= 1'b0;
        end else begin
            r_pc <= w_next_pc;
            if (redirect_valid_i && (redirect_pc_i[1:0] != 2'b00))
                r_misaligned <= 1'b1;
        end
    end

    // Driven from the PC flop only so redirect inputs cannot glitch it.
    assign imem_addr_o  = r_pc[IMEM_AW+1:2];
    assign misaligned_o = r_misaligned;

    if_id_reg u_if_id_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_ctrl  (w_ifid_ctrl),
        .i_pc    (r_pc),
        .i_pc4   (w_pc4),
        .i_instr (imem_rdata_i),
        .o_valid (ifid_valid_o),
        .o_pc    (ifid_pc_o),
        .o_pc4   (ifid_pc4_o),
        .o_instr (ifid_instr_o)
    );

`ifdef IF_PERF_CNT_EN
    logic [XLEN-1:0] r_fetch_cnt;
    logic [XLEN-1:0] r_stall_cnt;
    logic [XLEN-1:0] r_flush_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_cnt <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_load)
                r_fetch_cnt <= sat_inc(r_fetch_cnt);
            if (stall_i && !redirect_valid_i)
                r_stall_cnt <= sat_inc(r_stall_cnt);
            if (w_bubble)
                r_flush_cnt <= sat_inc(r_flush_cnt);
        end
    end

    assign perf_fetch_cnt_o = r_fetch_cnt;
    assign perf_stall_cnt_o = r_stall_cnt;
    assign perf_flush_cnt_o = r_flush_cnt;
`else
    logic w_unused_load;
    assign w_unused_load    = w_load;
    assign perf_fetch_cnt_o = '0;
    assign perf_stall_cnt_o = '0;
    assign perf_flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

    localparam int unsigned AW = 8;
`ifdef IF_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          stall_i = 1'b0;
    logic          flush_i = 1'b0;
    logic          redirect_valid_i = 1'b0;
    logic [31:0]   redirect_pc_i = '0;
    logic [AW-1:0] imem_addr_o;
    logic [31:0]   imem_rdata_i;
    logic          ifid_valid_o;
    logic [31:0]   ifid_pc_o, ifid_pc4_o, ifid_instr_o;
    logic          misaligned_o;
    logic [31:0]   perf_fetch_cnt_o, perf_stall_cnt_o, perf_flush_cnt_o;

    logic [31:0] mem [256];
    assign imem_rdata_i = mem[imem_addr_o];

    if_stage #(.RESET_PC(32'h0000_0000), .IMEM_AW(AW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stall_i          (stall_i),
        .flush_i          (flush_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .imem_addr_o      (imem_addr_o),
        .imem_rdata_i     (imem_rdata_i),
        .ifid_valid_o     (ifid_valid_o),
        .ifid_pc_o        (ifid_pc_o),
        .ifid_pc4_o       (ifid_pc4_o),
        .ifid_instr_o     (ifid_instr_o),
        .misaligned_o     (misaligned_o),
        .perf_fetch_cnt_o (perf_fetch_cnt_o),
        .perf_stall_cnt_o (perf_stall_cnt_o),
        .perf_flush_cnt_o (perf_flush_cnt_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Reference model: architectural state as the rules describe it.
    logic [31:0] m_pc, m_ipc, m_ipc4, m_instr;
    logic        m_valid, m_mis;
    logic [31:0] m_fc, m_sc, m_flc;

    task automatic model_reset();
        m_pc = 32'h0; m_valid = 0; m_ipc = 0; m_ipc4 = 0; m_instr = 0;
        m_mis = 0; m_fc = 0; m_sc = 0; m_flc = 0;
    endtask

    // Advance one rising edge, updating the model with the inputs in force.
    task automatic step();
        logic [31:0] npc;
        logic [31:0] cur_pc;
        cur_pc = m_pc;
        if (redirect_valid_i) npc = redirect_pc_i & 32'hFFFF_FFFC;
        else if (stall_i)     npc = cur_pc;
        else                  npc = cur_pc + 32'd4;
        if (redirect_valid_i && redirect_pc_i[1:0] != 2'b00) m_mis = 1'b1;
        if (flush_i || redirect_valid_i) begin
            m_valid = 0; m_ipc = 0; m_ipc4 = 0; m_instr = 0;
            if (m_flc != 32'hFFFF_FFFF) m_flc = m_flc + 1;
        end else if (!stall_i) begin
            m_valid = 1; m_ipc = cur_pc; m_ipc4 = cur_pc + 32'd4;
            m_instr = mem[cur_pc[9:2]];
            if (m_fc != 32'hFFFF_FFFF) m_fc = m_fc + 1;
        end
        if (stall_i && !redirect_valid_i && m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
        m_pc = npc;
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic st, input logic fl, input logic rv, input logic [31:0] rp);
        stall_i = st; flush_i = fl; redirect_valid_i = rv; redirect_pc_i = rp;
    endtask

    task automatic do_reset();
        set_in(0, 0, 0, 32'h0);
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #2;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        set_in(0, 0, 0, 32'h0);
        rst_n = 1'b0;
        model_reset();
        #3;
        total++; if (ifid_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", ifid_valid_o); end
        total++; if (ifid_pc_o !== 32'h0 || ifid_pc4_o !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h/%h exp=0/0", ifid_pc_o, ifid_pc4_o); end
        total++; if (ifid_instr_o !== 32'h0) begin bad++; $display("FAIL reset_instr got=%h exp=0", ifid_instr_o); end
        total++; if (imem_addr_o !== 8'h0 || misaligned_o !== 1'b0) begin bad++; $display("FAIL reset_addr_mis got=%h/%b exp=0/0", imem_addr_o, misaligned_o); end
        total++; if ((perf_fetch_cnt_o | perf_stall_cnt_o | perf_flush_cnt_o) !== 32'h0) begin bad++; $display("FAIL reset_perf got=%h/%h/%h exp=0", perf_fetch_cnt_o, perf_stall_cnt_o, perf_flush_cnt_o); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_free_run();
        repeat (3) step();
        total++; if (ifid_pc_o !== 32'h8) begin bad++; $display("FAIL free_pc got=%h exp=8", ifid_pc_o); end
        total++; if (ifid_instr_o !== 32'h2000_0002) begin bad++; $display("FAIL free_instr got=%h exp=20000002", ifid_instr_o); end
        total++; if (ifid_valid_o !== 1'b1 || ifid_pc4_o !== 32'hC) begin bad++; $display("FAIL free_valid_pc4 got=%b/%h exp=1/c", ifid_valid_o, ifid_pc4_o); end
        total++; if (imem_addr_o !== 8'd3) begin bad++; $display("FAIL free_addr got=%0d exp=3", imem_addr_o); end
    endtask

    task automatic test_stall();
        do_reset();
        repeat (2) step();
        set_in(1, 0, 0, 32'h0);
        repeat (2) begin
            step();
            total++; if (ifid_pc_o !== 32'h4 || ifid_instr_o !== 32'h2000_0001) begin bad++; $display("FAIL stall_hold got=%h/%h exp=4/20000001", ifid_pc_o, ifid_instr_o); end
            total++; if (imem_addr_o !== 8'd2) begin bad++; $display("FAIL stall_pc got=%0d exp=2", imem_addr_o); end
        end
        set_in(0, 0, 0, 32'h0);
        step();
        total++; if (ifid_pc_o !== 32'h8 || ifid_valid_o !== 1'b1) begin bad++; $display("FAIL stall_resume got=%h/%b exp=8/1", ifid_pc_o, ifid_valid_o); end
    endtask

    task automatic test_redirect_stall();
        set_in(1, 0, 1, 32'h40);
        step();
        total++; if (ifid_valid_o !== 1'b0 || ifid_instr_o !== 32'h0) begin bad++; $display("FAIL redir_bubble got=%b/%h exp=0/0", ifid_valid_o, ifid_instr_o); end
        total++; if (imem_addr_o !== 8'h10) begin bad++; $display("FAIL redir_pc got=%h exp=10", imem_addr_o); end
        set_in(0, 0, 0, 32'h0);
        step();
        total++; if (ifid_pc_o !== 32'h40 || ifid_instr_o !== 32'h2000_0010) begin bad++; $display("FAIL redir_target got=%h/%h exp=40/20000010", ifid_pc_o, ifid_instr_o); end
    endtask

    task automatic test_misaligned();
        set_in(0, 0, 1, 32'h42);
        step();
        total++; if (imem_addr_o !== 8'h10 || misaligned_o !== 1'b1) begin bad++; $display("FAIL mis_set got=%h/%b exp=10/1", imem_addr_o, misaligned_o); end
        set_in(0, 0, 1, 32'h80);
        step();
        set_in(0, 0, 0, 32'h0);
        repeat (2) step();
        total++; if (misaligned_o !== 1'b1) begin bad++; $display("FAIL mis_sticky got=%b exp=1", misaligned_o); end
        do_reset();
        total++; if (misaligned_o !== 1'b0) begin bad++; $display("FAIL mis_clear got=%b exp=0", misaligned_o); end
    endtask

    task automatic test_wrap_and_async_reset();
        set_in(0, 0, 1, 32'hFFFF_FFFC);
        step();
        total++; if (imem_addr_o !== 8'hFF) begin bad++; $display("FAIL wrap_addr got=%h exp=ff", imem_addr_o); end
        set_in(0, 0, 0, 32'h0);
        step();
        total++; if (ifid_pc_o !== 32'hFFFF_FFFC || ifid_pc4_o !== 32'h0) begin bad++; $display("FAIL wrap_pc4 got=%h/%h exp=fffffffc/0", ifid_pc_o, ifid_pc4_o); end
        total++; if (imem_addr_o !== 8'h0 || ifid_instr_o !== 32'h2000_00FF) begin bad++; $display("FAIL wrap_next got=%h/%h exp=0/200000ff", imem_addr_o, ifid_instr_o); end
        set_in(1, 0, 1, 32'h0000_0084);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        total++; if (ifid_valid_o !== 1'b0 || ifid_pc_o !== 32'h0 || ifid_pc4_o !== 32'h0 || ifid_instr_o !== 32'h0) begin bad++; $display("FAIL async_ifid got=%b/%h/%h/%h exp=0", ifid_valid_o, ifid_pc_o, ifid_pc4_o, ifid_instr_o); end
        total++; if (imem_addr_o !== 8'h0) begin bad++; $display("FAIL async_addr got=%h exp=0", imem_addr_o); end
        set_in(0, 0, 0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        step();
        total++; if (ifid_pc_o !== 32'h0 || ifid_valid_o !== 1'b1 || imem_addr_o !== 8'd1) begin bad++; $display("FAIL async_no_pending got=%h/%b/%h exp=0/1/1", ifid_pc_o, ifid_valid_o, imem_addr_o); end
    endtask

    task automatic test_perf();
        do_reset();
        repeat (10) step();
        set_in(1, 0, 0, 32'h0);
        repeat (3) step();
        set_in(0, 1, 0, 32'h0);
        repeat (2) step();
        set_in(0, 0, 0, 32'h0);
        total++; if (perf_fetch_cnt_o !== (PERF ? 32'd10 : 32'd0)) begin bad++; $display("FAIL perf_fetch got=%0d exp=%0d", perf_fetch_cnt_o, PERF ? 10 : 0); end
        total++; if (perf_stall_cnt_o !== (PERF ? 32'd3 : 32'd0)) begin bad++; $display("FAIL perf_stall got=%0d exp=%0d", perf_stall_cnt_o, PERF ? 3 : 0); end
        total++; if (perf_flush_cnt_o !== (PERF ? 32'd2 : 32'd0)) begin bad++; $display("FAIL perf_flush got=%0d exp=%0d", perf_flush_cnt_o, PERF ? 2 : 0); end
    endtask

    task automatic test_random();
        logic [31:0] rp;
        do_reset();
        for (int unsigned n = 0; n < 400; n++) begin
            rp = $urandom;
            set_in($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
                   $urandom_range(0, 9) == 0, rp);
            step();
            total++; if (imem_addr_o !== m_pc[9:2]) begin bad++; $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", n, imem_addr_o, m_pc[9:2]); end
            total++; if (ifid_valid_o !== m_valid || ifid_pc_o !== m_ipc || ifid_pc4_o !== m_ipc4 || ifid_instr_o !== m_instr) begin
                bad++; $display("FAIL rnd_ifid cyc=%0d got=%b/%h/%h/%h exp=%b/%h/%h/%h", n, ifid_valid_o, ifid_pc_o, ifid_pc4_o, ifid_instr_o, m_valid, m_ipc, m_ipc4, m_instr);
            end
            total++; if (misaligned_o !== m_mis) begin bad++; $display("FAIL rnd_mis cyc=%0d got=%b exp=%b", n, misaligned_o, m_mis); end
            total++; if (perf_fetch_cnt_o !== (PERF ? m_fc : 32'h0) || perf_stall_cnt_o !== (PERF ? m_sc : 32'h0) || perf_flush_cnt_o !== (PERF ? m_flc : 32'h0)) begin
                bad++; $display("FAIL rnd_perf cyc=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", n, perf_fetch_cnt_o, perf_stall_cnt_o, perf_flush_cnt_o, PERF ? m_fc : 0, PERF ? m_sc : 0, PERF ? m_flc : 0);
            end
        end
        set_in(0, 0, 0, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h2000_0000 + 32'(i);
        test_reset();
        test_free_run();
        test_stall();
        test_redirect_stall();
        test_misaligned();
        test_wrap_and_async_reset();
        test_perf();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
